// File: rtl/sram_port0_arb.sv
// sram_port0_arb: two-requester round-robin arbiter in front of the
// read/write port (port 0) of a single-ported-per-port SRAM macro.
// One access is in flight at a time: IDLE (grant) -> CMD (csb0 low) ->
// RDATA (reads only, SRAM dout passed straight through to rdata).
// Writes that hit the address currently being read on port 1 are held
// off for that IDLE cycle so the two ports never touch the same word.

// Per-requester eligibility: a pending request is eligible unless it is
// a write colliding with an active port-1 read of the same word.
module sram_port0_arb_elig #(
  parameter int AW = 9
) (
  input  logic          req_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic          p1_csb_i,
  input  logic [AW-1:0] p1_addr_i,
  output logic          elig_o
);

  logic collide;

  // Only writes are deferred; a read of the same word is harmless.
  assign collide = we_i & ~p1_csb_i & (p1_addr_i == addr_i);
  assign elig_o  = req_i & ~collide;

endmodule

module sram_port0_arb #(
  parameter int AW = 9,
  parameter int DW = 32,
  parameter int NM = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  // requester 0
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [NM-1:0] m0_wmask,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic          m0_rvalid,
  // requester 1
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [NM-1:0] m1_wmask,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic          m1_rvalid,
  // shared read data
  output logic [DW-1:0] rdata,
  // SRAM port 0 (read/write)
  output logic          sram_csb0,
  output logic          sram_web0,
  output logic [NM-1:0] sram_wmask0,
  output logic [AW-1:0] sram_addr0,
  output logic [DW-1:0] sram_din0,
  input  logic [DW-1:0] sram_dout0,
  // SRAM port 1 (read-only) snoop
  input  logic          p1_csb,
  input  logic [AW-1:0] p1_addr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CMD   = 2'd1;
  localparam logic [1:0] S_RDATA = 2'd2;

  // Requester fields gathered into packed arrays, index = requester id.
  logic [1:0]                req, we, elig, ack, rvalid;
  logic [1:0][NM-1:0]        wmask;
  logic [1:0][AW-1:0]        addr;
  logic [1:0][DW-1:0]        wdata;

  assign req   = {m1_req,   m0_req};
  assign we    = {m1_we,    m0_we};
  assign wmask = {m1_wmask, m0_wmask};
  assign addr  = {m1_addr,  m0_addr};
  assign wdata = {m1_wdata, m0_wdata};

  logic [1:0]    state_q, state_d;
  logic          ptr_q, ptr_d;      // favoured requester on a tie
  logic          owner_q, owner_d;  // requester of the access in flight
  logic          we_q, we_d;
  logic [NM-1:0] wmask_q, wmask_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;

  logic in_idle, in_cmd, in_rdata;
  logic gnt_any, gnt_idx;

  assign in_idle  = (state_q == S_IDLE);
  assign in_cmd   = (state_q == S_CMD);
  assign in_rdata = (state_q == S_RDATA);

  for (genvar g = 0; g < 2; g++) begin : g_req
    sram_port0_arb_elig #(.AW(AW)) u_elig (
      .req_i     (req[g]),
      .we_i      (we[g]),
      .addr_i    (addr[g]),
      .p1_csb_i  (p1_csb),
      .p1_addr_i (p1_addr),
      .elig_o    (elig[g])
    );
    // ack is combinational in the granting cycle; masked while in reset
    // so a requester holding req during reset never sees a stray ack.
    assign ack[g]    = gnt_any & (gnt_idx == 1'(g));
    assign rvalid[g] = in_rdata & (owner_q == 1'(g));
  end

  // Round-robin pick: the pointer breaks ties, a lone eligible one wins.
  always_comb begin
    gnt_any = in_idle & rst_n & (|elig);
    if (&elig) gnt_idx = ptr_q;
    else       gnt_idx = elig[1];
  end

  // Next-state, pointer and captured-command logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    we_d    = we_q;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    din_d   = din_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          state_d = S_CMD;
          ptr_d   = ~gnt_idx;
          owner_d = gnt_idx;
          we_d    = we[gnt_idx];
          wmask_d = wmask[gnt_idx];
          addr_d  = addr[gnt_idx];
          din_d   = wdata[gnt_idx];
        end
      end
      S_CMD:   state_d = we_q ? S_IDLE : S_RDATA;
      S_RDATA: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and command registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  // SRAM strobes are live only in CMD; addr/din simply hold between accesses.
  assign sram_csb0   = ~in_cmd;
  assign sram_web0   = in_cmd ? ~we_q : 1'b1;
  assign sram_wmask0 = in_cmd ? wmask_q : '0;
  assign sram_addr0  = addr_q;
  assign sram_din0   = din_q;

  assign m0_ack    = ack[0];
  assign m1_ack    = ack[1];
  assign m0_rvalid = rvalid[0];
  assign m1_rvalid = rvalid[1];
  assign rdata     = sram_dout0;

endmodule

// File: tb/tb_sram_port0_arb.sv
// Bench for sram_port0_arb: behavioural SRAM model on port 0, a table of
// request vectors with expected first-cycle acks and read data, a
// read-data scoreboard, a CMD-cycle strobe checker and hand-written
// sequences for back-to-back arbitration and reset mid-access.
module tb_sram_port0_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_wmask, m1_wmask;
  logic [8:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ack, m0_rvalid, m1_ack, m1_rvalid;
  logic [31:0] rdata;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0;
  logic [31:0] sram_din0, sram_dout0;
  logic        p1_csb;
  logic [8:0]  p1_addr;

  sram_port0_arb #(.AW(9), .DW(32), .NM(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_wmask(m0_wmask), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_wmask(m1_wmask), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rvalid(m1_rvalid),
    .rdata(rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .p1_csb(p1_csb), .p1_addr(p1_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM port-0 model: command sampled at the rising edge, dout registered.
  logic [31:0] mem [0:511];
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        r0, w0; logic [3:0] k0; logic [8:0] a0; logic [31:0] d0, x0;
    logic        r1, w1; logic [3:0] k1; logic [8:0] a1; logic [31:0] d1, x1;
    logic        pc; logic [8:0] pa; int ph;
    logic        e0, e1;
  } vec_t;

  typedef struct { logic own; logic [31:0] data; int cyc; } exp_t;
  exp_t sbq[$];

  // Details of the most recent grant, for the CMD-cycle checker.
  int          last_cyc = -10;
  logic        last_we;
  logic [3:0]  last_mask;
  logic [8:0]  last_addr;
  logic [31:0] last_data;

  function automatic vec_t mk(
    input logic r0, w0, input logic [3:0] k0, input logic [8:0] a0,
    input logic [31:0] d0, x0,
    input logic r1, w1, input logic [3:0] k1, input logic [8:0] a1,
    input logic [31:0] d1, x1,
    input logic pc, input logic [8:0] pa, input int ph, input logic e0, e1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.k0 = k0; v.a0 = a0; v.d0 = d0; v.x0 = x0;
    v.r1 = r1; v.w1 = w1; v.k1 = k1; v.a1 = a1; v.d1 = d1; v.x1 = x1;
    v.pc = pc; v.pa = pa; v.ph = ph; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic note(input int idx);
    logic        w;
    logic [8:0]  a;
    w = idx ? m1_we : m0_we;
    a = idx ? m1_addr : m0_addr;
    chk("no write collision at ack", w & !p1_csb & (p1_addr == a), 0);
    last_cyc  = cyc;
    last_we   = w;
    last_addr = a;
    last_mask = idx ? m1_wmask : m0_wmask;
    last_data = idx ? m1_wdata : m0_wdata;
  endtask

  task automatic take(input int idx, input logic [31:0] x);
    exp_t e;
    note(idx);
    if (!last_we) begin
      e.own = idx[0]; e.data = x; e.cyc = cyc + 2;
      sbq.push_back(e);
    end
  endtask

  // Applies one vector from IDLE, holds each req until acked, then drains.
  task automatic run_vec(input vec_t v, input string nm);
    int   t, left;
    logic a0, a1, first;
    m0_req = v.r0; m0_we = v.w0; m0_wmask = v.k0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.r1; m1_we = v.w1; m1_wmask = v.k1; m1_addr = v.a1; m1_wdata = v.d1;
    p1_csb = v.pc; p1_addr = v.pa; left = v.ph;
    first = 1'b1; t = 0;
    while ((m0_req || m1_req) && t < 40) begin
      @(negedge clk);
      a0 = m0_ack; a1 = m1_ack;
      chk({nm, " single ack"}, a0 & a1, 0);
      if (first) begin
        chk({nm, " first ack0"}, a0, v.e0);
        chk({nm, " first ack1"}, a1, v.e1);
        first = 1'b0;
      end
      if (a0) take(0, v.x0);
      if (a1) take(1, v.x1);
      @(posedge clk); #1;
      if (a0) m0_req = 1'b0;
      if (a1) m1_req = 1'b0;
      if (left > 0) begin
        left--;
        if (left == 0) p1_csb = 1'b1;
      end
      t++;
    end
    chk({nm, " all acked"}, m0_req | m1_req, 0);
    m0_req = 1'b0; m1_req = 1'b0; p1_csb = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Read-data scoreboard and port-0 strobe checker.
  always @(negedge clk) begin
    if (m0_rvalid || m1_rvalid) begin
      chk("single rvalid", m0_rvalid & m1_rvalid, 0);
      if (sbq.size() == 0) begin
        chk("rvalid expected", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rvalid owner", m1_rvalid, e.own);
        chk("rdata", rdata, e.data);
        chk("rvalid latency", cyc, e.cyc);
      end
    end
    if (rst_n) begin
      if (!sram_csb0) begin
        chk("cmd one cycle after ack", cyc, last_cyc + 1);
        chk("cmd web0", sram_web0, !last_we);
        chk("cmd addr0", sram_addr0, last_addr);
        if (last_we) begin
          chk("cmd wmask0", sram_wmask0, last_mask);
          chk("cmd din0", sram_din0, last_data);
        end
      end else begin
        chk("idle web0", sram_web0, 1);
        chk("idle wmask0", sram_wmask0, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t tv[15];

  initial begin
    int   n, t;
    int   gc[4];
    logic go[4];
    vec_t vr;

    //             r0 w0 k0   a0      d0            x0            r1 w1 k1   a1      d1            x1            pc a1p     ph e0 e1
    tv[0]  = mk(1, 1, 4'hF, 9'h010, 32'hDEADBEEF, 32'h0,        0, 0, 4'h0, 9'h000, 32'h0,        32'h0,        1, 9'h000, 0, 1, 0);
    tv[1]  = mk(1, 0, 4'h0, 9'h010, 32'h0,        32'hDEADBEEF, 0, 0, 4'h0, 9'h000, 32'h0,        32'h0,        1, 9'h000, 0, 1, 0);
    tv[2]  = mk(0, 0, 4'h0, 9'h000, 32'h0,        32'h0,        1, 1, 4'hF, 9'h000, 32'hA5A50001, 32'h0,        1, 9'h000, 0, 0, 1);
    tv[3]  = mk(1, 1, 4'hF, 9'h1FF, 32'h5A5A01FF, 32'h0,        0, 0, 4'h0, 9'h000, 32'h0,        32'h0,        1, 9'h000, 0, 1, 0);
    tv[4]  = mk(1, 0, 4'h0, 9'h000, 32'h0,        32'hA5A50001, 1, 0, 4'h0, 9'h1FF, 32'h0,        32'h5A5A01FF, 1, 9'h000, 0, 0, 1);
    tv[5]  = mk(1, 1, 4'hF, 9'h020, 32'hFFFFFFFF, 32'h0,        0, 0, 4'h0, 9'h000, 32'h0,        32'h0,        1, 9'h000, 0, 1, 0);
    tv[6]  = mk(0, 0, 4'h0, 9'h000, 32'h0,        32'h0,        1, 1, 4'h2, 9'h020, 32'h11223344, 32'h0,        1, 9'h000, 0, 0, 1);
    tv[7]  = mk(0, 0, 4'h0, 9'h000, 32'h0,        32'h0,        1, 0, 4'h0, 9'h020, 32'h0,        32'hFFFF33FF, 1, 9'h000, 0, 0, 1);
    tv[8]  = mk(1, 1, 4'hF, 9'h030, 32'hC0DE0030, 32'h0,        1, 1, 4'hF, 9'h005, 32'hC0DE0005, 32'h0,        1, 9'h000, 0, 1, 0);
    tv[9]  = mk(0, 0, 4'h0, 9'h000, 32'h0,        32'h0,        1, 1, 4'h0, 9'h030, 32'hFFFFFFFF, 32'h0,        1, 9'h000, 0, 0, 1);
    tv[10] = mk(1, 0, 4'h0, 9'h030, 32'h0,        32'hC0DE0030, 0, 0, 4'h0, 9'h000, 32'h0,        32'h0,        1, 9'h000, 0, 1, 0);
    tv[11] = mk(1, 0, 4'h0, 9'h005, 32'h0,        32'hC0DE0005, 1, 1, 4'hF, 9'h1FF, 32'h0BADF00D, 32'h0,        0, 9'h1FF, 5, 1, 0);
    tv[12] = mk(1, 0, 4'h0, 9'h1FF, 32'h0,        32'h0BADF00D, 0, 0, 4'h0, 9'h000, 32'h0,        32'h0,        0, 9'h1FF, 2, 1, 0);
    tv[13] = mk(1, 1, 4'hF, 9'h000, 32'h12345678, 32'h0,        0, 0, 4'h0, 9'h000, 32'h0,        32'h0,        0, 9'h001, 2, 1, 0);
    tv[14] = mk(0, 0, 4'h0, 9'h000, 32'h0,        32'h0,        1, 0, 4'h0, 9'h000, 32'h0,        32'h12345678, 1, 9'h000, 0, 0, 1);

    // Reset state, with a request already pending.
    rst_n = 1'b0; p1_csb = 1'b1; p1_addr = '0;
    m0_req = 1'b1; m0_we = 1'b0; m0_wmask = '0; m0_addr = 9'h010; m0_wdata = '0;
    m1_req = 1'b1; m1_we = 1'b1; m1_wmask = '1; m1_addr = 9'h011; m1_wdata = '1;
    #2;
    chk("reset ack0", m0_ack, 0);
    chk("reset ack1", m1_ack, 0);
    chk("reset rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("reset csb0", sram_csb0, 1);
    chk("reset web0", sram_web0, 1);
    chk("reset wmask0", sram_wmask0, 0);
    chk("reset addr0", sram_addr0, 0);
    chk("reset din0", sram_din0, 0);
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(tv[i], $sformatf("vec%0d", i));

    // Both requesters reading continuously: strict alternation, 3 cycles apart.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h010;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'h020;
    n = 0; t = 0;
    while (n < 4 && t < 40) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        go[n] = m1_ack;
        gc[n] = cyc;
        take(m1_ack ? 1 : 0, m1_ack ? 32'hFFFF33FF : 32'hDEADBEEF);
        n++;
      end
      @(posedge clk); #1;
      t++;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk("alt grant count", n, 4);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("alt owner %0d", i), go[i], i % 2);
      if (i > 0) chk($sformatf("alt gap %0d", i), gc[i] - gc[i-1], 3);
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset while a read sits in RDATA: no rvalid, strobes idle at once.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h010;
    @(negedge clk);
    chk("rst-seq ack0", m0_ack, 1);
    if (m0_ack) note(0);
    @(posedge clk); #1;
    m0_req = 1'b0;
    @(posedge clk); #1;
    chk("rst-seq in rdata", m0_rvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst-seq rvalid0", m0_rvalid, 0);
    chk("rst-seq rvalid1", m1_rvalid, 0);
    chk("rst-seq csb0", sram_csb0, 1);
    chk("rst-seq addr0", sram_addr0, 0);
    @(posedge clk); #1;
    chk("rst-seq csb0 held", sram_csb0, 1);
    rst_n = 1'b1;
    // Pointer back on m0 after reset, grant in the very first cycle.
    vr = mk(1, 0, 4'h0, 9'h1FF, 32'h0, 32'h0BADF00D, 1, 0, 4'h0, 9'h000, 32'h0, 32'h12345678,
            1, 9'h000, 0, 1, 0);
    run_vec(vr, "post-reset");

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end

endmodule
